weight_bram_reader: RTL and testbench

Read sequencer between the weight BRAM and the weight preload path of the MAC array. It takes single-word or dual-word read requests from the load-weight control FSM and generates port A/B addresses and enables on the dual-port weight BRAM. Returned words are registered and presented with a one-cycle `data_valid` strobe. It also tracks the weight region bounds and flags completion when the last word has been fetched.

---
 rtl/weight_bram_reader_pkg.sv | 27 ++
 rtl/weight_bram_reader_addr_gen.sv | 86 ++++++++
 rtl/weight_bram_reader.sv | 128 ++++++++++++
 tb/tb_weight_bram_reader.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/weight_bram_reader_pkg.sv
// Shared definitions for the weight BRAM read sequencer.
//   state_t       : sequencer FSM encoding (ST_WAIT2 only reachable when
//                   WEIGHT_BRAM_OUTREG_EN is defined)
//   WEIGHT_W      : weight word width for the default MAC count (5*MAC_NUM)
//   LEN_ONE/TWO   : read_len encodings
//   weight_width(): word width for an arbitrary MAC count
package weight_bram_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_WAIT    = 3'd2,
    ST_WAIT2   = 3'd3,
    ST_CAPTURE = 3'd4
  } state_t;

  localparam int MAC_NUM_DEFAULT = 256;
  localparam int WEIGHT_W        = 5 * MAC_NUM_DEFAULT;

  localparam logic LEN_ONE = 1'b0;
  localparam logic LEN_TWO = 1'b1;

  function automatic int weight_width(input int mac_num);
    return 5 * mac_num;
  endfunction

endpackage

// File: rtl/weight_bram_reader_addr_gen.sv
// Read pointer, region bound tracking and BRAM address/enable generation.
// Ports:
//   clk, rst_n               : clock, asynchronous active-low reset
//   address_reset            : reload ptr from base_addr, latch end_addr
//   base_addr, end_addr      : weight region bounds (end inclusive)
//   accept                   : request accepted this cycle (FSM in IDLE)
//   read_len                 : LEN_ONE / LEN_TWO of the accepted request
//   overrun_req              : request seen while finished
//   bram_en_a/b, bram_addr_a/b : registered BRAM port controls (high in READ)
//   load_weight_finish       : region exhausted
//   overrun                  : sticky request-after-finish flag
module weight_bram_addr_gen
  import weight_bram_reader_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          address_reset,
  input  logic [AW-1:0] base_addr,
  input  logic [AW-1:0] end_addr,
  input  logic          accept,
  input  logic          read_len,
  input  logic          overrun_req,
  output logic          bram_en_a,
  output logic          bram_en_b,
  output logic [AW-1:0] bram_addr_a,
  output logic [AW-1:0] bram_addr_b,
  output logic          load_weight_finish,
  output logic          overrun
);

  // One extra bit so ptr can step past end_addr = 2^AW-1 without wrapping.
  logic [AW:0]   ptr;
  logic [AW-1:0] end_q;
  logic [AW:0]   end_ext;
  logic          two_words;
  logic [AW:0]   ptr_next;

  assign end_ext   = {1'b0, end_q};
  // The second word exists only if the first one is not already the last.
  assign two_words = (read_len == LEN_TWO) && (ptr != end_ext);
  // bram_en_a is high exactly in READ; bram_en_b tells how many words went out.
  assign ptr_next  = ptr + (bram_en_b ? (AW+1)'(2) : (AW+1)'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr                <= '0;
      end_q              <= '0;
      bram_en_a          <= 1'b0;
      bram_en_b          <= 1'b0;
      bram_addr_a        <= '0;
      bram_addr_b        <= '0;
      load_weight_finish <= 1'b0;
      overrun            <= 1'b0;
    end else if (address_reset) begin
      ptr                <= {1'b0, base_addr};
      end_q              <= end_addr;
      bram_en_a          <= 1'b0;
      bram_en_b          <= 1'b0;
      load_weight_finish <= (base_addr > end_addr);
      overrun            <= 1'b0;
    end else begin
      bram_en_a <= accept;
      bram_en_b <= accept && two_words;
      if (accept) begin
        bram_addr_a <= ptr[AW-1:0];
        if (two_words) begin
          bram_addr_b <= ptr[AW-1:0] + AW'(1);
        end
      end
      // Pointer advances at the end of READ, so finish shows up one cycle
      // after the enables and ahead of the matching data_valid.
      if (bram_en_a) begin
        ptr <= ptr_next;
        if (ptr_next > end_ext) begin
          load_weight_finish <= 1'b1;
        end
      end
      if (overrun_req) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/weight_bram_reader.sv
// Read sequencer from the dual-port weight BRAM to the MAC weight preload path.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   address_reset         : clear pointer to base_addr, abort in-flight fetch
//   base_addr, end_addr   : weight region (end inclusive)
//   read_en, read_len     : request level and length (0 = one word, 1 = two)
//   bram_en_*/bram_addr_* : BRAM port controls
//   bram_dout_a/b         : BRAM read data
//   weight_a/b            : captured words, valid with the data_valid strobe
//   data_valid            : one-cycle strobe for new weight_a/weight_b
//   load_weight_finish    : region exhausted
//   overrun               : sticky request-after-finish flag
// Build option: define WEIGHT_BRAM_OUTREG_EN when the BRAM output register is
// enabled; this adds a WAIT2 state and raises read latency from 3 to 4.
module weight_bram_reader
  import weight_bram_reader_pkg::*;
#(
  parameter int MAC_NUM            = 256,
  parameter int BRAM_ADDRESS_WIDTH = 12
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          address_reset,
  input  logic [BRAM_ADDRESS_WIDTH-1:0] base_addr,
  input  logic [BRAM_ADDRESS_WIDTH-1:0] end_addr,
  input  logic                          read_en,
  input  logic                          read_len,
  output logic                          bram_en_a,
  output logic                          bram_en_b,
  output logic [BRAM_ADDRESS_WIDTH-1:0] bram_addr_a,
  output logic [BRAM_ADDRESS_WIDTH-1:0] bram_addr_b,
  input  logic [5*MAC_NUM-1:0]          bram_dout_a,
  input  logic [5*MAC_NUM-1:0]          bram_dout_b,
  output logic [5*MAC_NUM-1:0]          weight_a,
  output logic [5*MAC_NUM-1:0]          weight_b,
  output logic                          data_valid,
  output logic                          load_weight_finish,
  output logic                          overrun
);

  localparam int WW = weight_width(MAC_NUM);

  state_t state, state_next;
  logic   accept;
  logic   overrun_req;
  logic   b_used;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    overrun_req = 1'b0;
    case (state)
      ST_IDLE: begin
        // read_en is only looked at here, so a requester may hold it.
        if (read_en && !address_reset) begin
          if (load_weight_finish) begin
            overrun_req = 1'b1;
          end else begin
            accept     = 1'b1;
            state_next = ST_READ;
          end
        end
      end
      ST_READ: state_next = ST_WAIT;
`ifdef WEIGHT_BRAM_OUTREG_EN
      ST_WAIT: state_next = ST_WAIT2;
`else
      ST_WAIT: state_next = ST_CAPTURE;
`endif
      ST_WAIT2:   state_next = ST_CAPTURE;
      ST_CAPTURE: state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
    if (address_reset) begin
      state_next = ST_IDLE;
    end
  end

  weight_bram_addr_gen #(
    .AW(BRAM_ADDRESS_WIDTH)
  ) u_addr_gen (
    .clk                (clk),
    .rst_n              (rst_n),
    .address_reset      (address_reset),
    .base_addr          (base_addr),
    .end_addr           (end_addr),
    .accept             (accept),
    .read_len           (read_len),
    .overrun_req        (overrun_req),
    .bram_en_a          (bram_en_a),
    .bram_en_b          (bram_en_b),
    .bram_addr_a        (bram_addr_a),
    .bram_addr_b        (bram_addr_b),
    .load_weight_finish (load_weight_finish),
    .overrun            (overrun)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      weight_a   <= '0;
      weight_b   <= '0;
      data_valid <= 1'b0;
      b_used     <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      // An address_reset aborts the fetch: no capture and no strobe.
      if (!address_reset) begin
        if (state == ST_READ) begin
          b_used <= bram_en_b;
        end
        if (state == ST_CAPTURE) begin
          weight_a   <= bram_dout_a;
          weight_b   <= b_used ? bram_dout_b : WW'(0);
          data_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_weight_bram_reader.sv
module tb_weight_bram_reader;
  import weight_bram_reader_pkg::*;

  localparam int MAC  = 256;
  localparam int AW   = 12;
  localparam int W    = 5 * MAC;
  localparam int MAXC = 1500;
`ifdef WEIGHT_BRAM_OUTREG_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          address_reset = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] end_addr = '0;
  logic          read_en = 1'b0;
  logic          read_len = 1'b0;
  logic          bram_en_a, bram_en_b;
  logic [AW-1:0] bram_addr_a, bram_addr_b;
  logic [W-1:0]  bram_dout_a, bram_dout_b;
  logic [W-1:0]  weight_a, weight_b;
  logic          data_valid, load_weight_finish, overrun;

  weight_bram_reader #(.MAC_NUM(MAC), .BRAM_ADDRESS_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .address_reset(address_reset),
    .base_addr(base_addr), .end_addr(end_addr),
    .read_en(read_en), .read_len(read_len),
    .bram_en_a(bram_en_a), .bram_en_b(bram_en_b),
    .bram_addr_a(bram_addr_a), .bram_addr_b(bram_addr_b),
    .bram_dout_a(bram_dout_a), .bram_dout_b(bram_dout_b),
    .weight_a(weight_a), .weight_b(weight_b),
    .data_valid(data_valid), .load_weight_finish(load_weight_finish),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory content: every 32-bit lane holds {A, address, lane index}.
  function automatic logic [W-1:0] pat(input logic [AW-1:0] a);
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = {4'hA, a, 16'(i)};
    return v;
  endfunction

  // BRAM model: registered read, optional output register stage.
  logic [W-1:0] ram_a = '0, ram_b = '0;
  always @(posedge clk) begin
    if (bram_en_a) ram_a <= pat(bram_addr_a);
    if (bram_en_b) ram_b <= pat(bram_addr_b);
  end
`ifdef WEIGHT_BRAM_OUTREG_EN
  always @(posedge clk) begin
    bram_dout_a <= ram_a;
    bram_dout_b <= ram_b;
  end
`else
  assign bram_dout_a = ram_a;
  assign bram_dout_b = ram_b;
`endif

  // ---------------- behavioural model (transaction level) ----------------
  int           m_ptr = 0, m_end = 0, busy_until = 0;
  bit           m_fin = 0;
  bit           fin_lvl [MAXC];
  bit           ovr_lvl [MAXC];
  int           ea_sched [int];
  int           eb_sched [int];
  logic [W-1:0] wa_sched [int];
  logic [W-1:0] wb_sched [int];
  bit           rst_ev [int];
  int           acc_q [$];
  int           obs_a [$];
  int           obs_b [$];
  int           obs_dv [$];
  int           n_chk = 0, n_fail = 0;

  function automatic void fill_fin(input int from, input bit v);
    for (int k = from; k < MAXC; k++) fin_lvl[k] = v;
  endfunction

  function automatic void fill_ovr(input int from, input bit v);
    for (int k = from; k < MAXC; k++) ovr_lvl[k] = v;
  endfunction

  function automatic void cancel_from(input int from);
    for (int k = from; k < from + 12; k++) begin
      if (ea_sched.exists(k)) ea_sched.delete(k);
      if (eb_sched.exists(k)) eb_sched.delete(k);
      if (wa_sched.exists(k)) wa_sched.delete(k);
      if (wb_sched.exists(k)) wb_sched.delete(k);
    end
  endfunction

  // read_en seen high in cycle c with the given length.
  function automatic void model_read(input int c, input bit len);
    bit two;
    if (c < busy_until) return;
    if (m_fin) begin
      fill_ovr(c + 1, 1'b1);
      return;
    end
    two = len && (m_ptr != m_end);
    ea_sched[c+1] = m_ptr;
    if (two) eb_sched[c+1] = m_ptr + 1;
    wa_sched[c+1+LAT] = pat(AW'(m_ptr));
    wb_sched[c+1+LAT] = two ? pat(AW'(m_ptr + 1)) : '0;
    acc_q.push_back(c);
    m_ptr += two ? 2 : 1;
    if (m_ptr > m_end) begin
      m_fin = 1'b1;
      fill_fin(c + 2, 1'b1);
    end
    busy_until = c + 1 + LAT;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- per-cycle compare process ----------------
  logic [AW-1:0] h_aa = '0, h_ab = '0;
  logic [W-1:0]  h_wa = '0, h_wb = '0;

  always @(negedge clk) begin
    int  c;
    bit  e_a, e_b, e_dv;
    c = cyc;
    if (c >= 2 && c < MAXC) begin
      if (rst_ev.exists(c)) begin
        h_aa = '0; h_ab = '0; h_wa = '0; h_wb = '0;
      end
      e_a  = ea_sched.exists(c);
      e_b  = eb_sched.exists(c);
      e_dv = wa_sched.exists(c);
      if (e_a) h_aa = AW'(ea_sched[c]);
      if (e_b) h_ab = AW'(eb_sched[c]);
      if (e_dv) begin
        h_wa = wa_sched[c];
        h_wb = wb_sched[c];
      end
      check("bram_en_a", 64'(bram_en_a), 64'(e_a));
      check("bram_en_b", 64'(bram_en_b), 64'(e_b));
      check("bram_addr_a", 64'(bram_addr_a), 64'(h_aa));
      check("bram_addr_b", 64'(bram_addr_b), 64'(h_ab));
      check("data_valid", 64'(data_valid), 64'(e_dv));
      check("finish", 64'(load_weight_finish), 64'(fin_lvl[c]));
      check("overrun", 64'(overrun), 64'(ovr_lvl[c]));
      n_chk++;
      if (weight_a !== h_wa) begin
        n_fail++;
        $display("FAIL weight_a: got low %0h expected low %0h (cycle %0d)",
                 weight_a[63:0], h_wa[63:0], c);
      end
      n_chk++;
      if (weight_b !== h_wb) begin
        n_fail++;
        $display("FAIL weight_b: got low %0h expected low %0h (cycle %0d)",
                 weight_b[63:0], h_wb[63:0], c);
      end
      if (bram_en_a === 1'b1) obs_a.push_back(int'(bram_addr_a));
      if (bram_en_b === 1'b1) obs_b.push_back(int'(bram_addr_b));
      if (data_valid === 1'b1) obs_dv.push_back(c);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drive_read(input bit len, input int ncyc);
    read_en  = 1'b1;
    read_len = len;
    for (int i = 0; i < ncyc; i++) begin
      model_read(cyc, len);
      tick();
    end
    read_en = 1'b0;
  endtask

  task automatic do_req(input bit len);
    drive_read(len, 1);
    while (cyc < busy_until) tick();
  endtask

  task automatic addr_rst(input int b, input int e, input bit with_read);
    int c;
    c = cyc;
    address_reset = 1'b1;
    base_addr     = AW'(b);
    end_addr      = AW'(e);
    read_en       = with_read;
    m_ptr = b; m_end = e; m_fin = (b > e);
    fill_fin(c + 1, m_fin);
    fill_ovr(c + 1, 1'b0);
    cancel_from(c + 1);
    busy_until = c + 1;
    tick();
    address_reset = 1'b0;
    read_en       = 1'b0;
  endtask

  task automatic pulse_rst();
    int c;
    c = cyc;
    rst_n = 1'b0;
    rst_ev[c] = 1'b1;
    cancel_from(c);
    fill_fin(c, 1'b0);
    fill_ovr(c, 1'b0);
    m_ptr = 0; m_end = 0; m_fin = 0; busy_until = 0;
    wait_cycles(2);
    rst_n = 1'b1;
  endtask

  task automatic clear_obs();
    obs_a.delete(); obs_b.delete(); obs_dv.delete(); acc_q.delete();
  endtask

  initial begin
    wait_cycles(3);
    rst_n = 1'b1;
    tick();

    // Region 0..3, four single-word reads.
    addr_rst(0, 3, 1'b0);
    clear_obs();
    for (int i = 0; i < 4; i++) do_req(1'b0);
    wait_cycles(1);
    check("s1_count", 64'(obs_a.size()), 64'd4);
    for (int i = 0; i < 4 && i < obs_a.size(); i++) check("s1_addr", 64'(obs_a[i]), 64'(i));
    if (obs_dv.size() > 0 && acc_q.size() > 0)
      check("s1_latency", 64'(obs_dv[0] - (acc_q[0] + 1)), 64'(LAT));
    else check("s1_latency_seen", 64'(obs_dv.size()), 64'd1);
    check("s1_finish", 64'(load_weight_finish), 64'd1);

    // Region 10..13, two dual-word reads.
    addr_rst(10, 13, 1'b0);
    clear_obs();
    do_req(1'b1);
    do_req(1'b1);
    wait_cycles(1);
    check("s2_a_count", 64'(obs_a.size()), 64'd2);
    check("s2_b_count", 64'(obs_b.size()), 64'd2);
    if (obs_a.size() == 2 && obs_b.size() == 2) begin
      check("s2_a0", 64'(obs_a[0]), 64'd10);
      check("s2_b0", 64'(obs_b[0]), 64'd11);
      check("s2_a1", 64'(obs_a[1]), 64'd12);
      check("s2_b1", 64'(obs_b[1]), 64'd13);
    end
    check("s2_weight_b_lane0", 64'(weight_b[31:0]), 64'hA00D_0000);
    check("s2_finish", 64'(load_weight_finish), 64'd1);

    // Region 0..2, len 1 twice: second read is A-only at the last word.
    addr_rst(0, 2, 1'b0);
    clear_obs();
    do_req(1'b1);
    do_req(1'b1);
    wait_cycles(1);
    check("s3_a_count", 64'(obs_a.size()), 64'd2);
    check("s3_b_count", 64'(obs_b.size()), 64'd1);
    if (obs_a.size() == 2) check("s3_a1", 64'(obs_a[1]), 64'd2);
    check("s3_weight_a_lane0", 64'(weight_a[31:0]), 64'hA002_0000);
    check("s3_weight_b_zero", weight_b[63:0], 64'd0);
    check("s3_finish", 64'(load_weight_finish), 64'd1);

    // Request after finish, then address_reset racing a request.
    clear_obs();
    drive_read(1'b0, 1);
    wait_cycles(LAT + 2);
    check("s4_no_fetch", 64'(obs_a.size()), 64'd0);
    check("s4_no_valid", 64'(obs_dv.size()), 64'd0);
    check("s4_overrun", 64'(overrun), 64'd1);
    addr_rst(0, 2, 1'b1);
    wait_cycles(LAT + 2);
    check("s4_overrun_clr", 64'(overrun), 64'd0);
    check("s4_finish_clr", 64'(load_weight_finish), 64'd0);
    check("s4_reset_wins", 64'(obs_a.size()), 64'd0);

    // address_reset while the fetch is in WAIT.
    addr_rst(40, 50, 1'b0);
    clear_obs();
    drive_read(1'b1, 1);
    tick();
    addr_rst(40, 50, 1'b0);
    wait_cycles(LAT + 2);
    check("s5_no_valid", 64'(obs_dv.size()), 64'd0);
    do_req(1'b0);
    wait_cycles(1);
    if (obs_a.size() > 0) check("s5_restart_addr", 64'(obs_a[obs_a.size()-1]), 64'd40);
    else check("s5_restart_seen", 64'(obs_a.size()), 64'd2);

    // read_en held high for 6 cycles on a one-word region.
    addr_rst(5, 5, 1'b0);
    clear_obs();
    drive_read(1'b0, 6);
    wait_cycles(LAT + 1);
    check("s6_one_fetch", 64'(obs_a.size()), 64'd1);
    check("s6_one_valid", 64'(obs_dv.size()), 64'd1);
    check("s6_overrun", 64'(overrun), 64'd1);

    // rst_n asserted mid-fetch.
    addr_rst(20, 30, 1'b0);
    clear_obs();
    drive_read(1'b1, 1);
    tick();
    pulse_rst();
    wait_cycles(LAT + 2);
    check("s6_rst_no_valid", 64'(obs_dv.size()), 64'd0);
    check("s6_rst_weight_a", weight_a[63:0], 64'd0);
    check("s6_rst_addr_a", 64'(bram_addr_a), 64'd0);

    // Recovery after reset.
    addr_rst(7, 9, 1'b0);
    do_req(1'b1);
    wait_cycles(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #(10 * 1200);
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
